// File: rtl/scan_sequencer.sv
// ============================================================================
// Module      : scan_sequencer
// Description : Steps the 4-bit select code of a 4-to-16 decoder through all
//               16 codes with a programmable dwell per code. Optional build
//               macro SCAN_SEQ_REVERSE_EN adds a descending-scan 'dir' input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SEQ_REVERSE_EN
    input  logic               dir,
`endif
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               valid,
    output logic               busy,
    output logic               step,
    output logic               done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;
    localparam logic [DWELL_W-1:0] c_cnt_one = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [0:0]         r_state;
    logic [3:0]         r_code;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_loop;
    logic               r_valid;
    logic               r_step;
    logic               r_done;

    logic [3:0]         w_start_code;
    logic [3:0]         w_last_code;
    logic [3:0]         w_next_code;

`ifdef SCAN_SEQ_REVERSE_EN
    logic               r_dir;

    // Start code is chosen from the live 'dir' because it is latched on the same edge.
    assign w_start_code = dir   ? 4'hF : 4'h0;
    assign w_last_code  = r_dir ? 4'h0 : 4'hF;
    assign w_next_code  = r_dir ? (r_code - 4'd1) : (r_code + 4'd1);
`else
    assign w_start_code = 4'h0;
    assign w_last_code  = 4'hF;
    assign w_next_code  = r_code + 4'd1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_code  <= 4'h0;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_loop  <= 1'b0;
            r_valid <= 1'b0;
            r_step  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SCAN_SEQ_REVERSE_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            r_step <= 1'b0;
            r_done <= 1'b0;
            if (stop) begin
                r_state <= S_IDLE;
                r_code  <= 4'h0;
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_code  <= 4'h0;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        if (start) begin
                            r_state <= S_SCAN;
                            r_loop  <= loop;
                            r_dwell <= dwell;
`ifdef SCAN_SEQ_REVERSE_EN
                            r_dir   <= dir;
`endif
                            r_code  <= w_start_code;
                            r_valid <= 1'b1;
                            r_step  <= 1'b1;
                        end
                    end
                    S_SCAN: begin
                        if (r_cnt == r_dwell) begin
                            r_cnt <= '0;
                            if (r_code != w_last_code) begin
                                r_code <= w_next_code;
                                r_step <= 1'b1;
                            end else if (r_loop) begin
                                r_code <= w_next_code;
                                r_step <= 1'b1;
                            end else begin
                                // Normal end of a single sweep.
                                r_state <= S_IDLE;
                                r_code  <= 4'h0;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_code  <= 4'h0;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign a     = r_code[3];
    assign b     = r_code[2];
    assign c     = r_code[1];
    assign d     = r_code[0];
    assign valid = r_valid;
    assign busy  = r_valid;
    assign step  = r_step;
    assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_scan_sequencer.sv
// ============================================================================
// Module      : tb_scan_sequencer
// Description : Directed self-checking bench for scan_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_sequencer;

    localparam int DWELL_W = 8;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic               loop;
    logic [DWELL_W-1:0] dwell;
    logic               dir;
    logic               a, b, c, d;
    logic               valid, busy, step, done;

    int n_tests;
    int n_fail;

    typedef struct {
        logic               start;
        logic               stop;
        logic               loop;
        logic [DWELL_W-1:0] dwell;
        logic [3:0]         exp_code;
        logic               exp_valid;
        logic               exp_step;
        logic               exp_done;
    } vec_t;

    vec_t vecs[19];

    scan_sequencer #(.DWELL_W(DWELL_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .loop  (loop),
        .dwell (dwell),
`ifdef SCAN_SEQ_REVERSE_EN
        .dir   (dir),
`endif
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .valid (valid),
        .busy  (busy),
        .step  (step),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic [3:0] code, input logic v,
                                      input logic s, input logic dn);
        return {code, v, v, s, dn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {a, b, c, d, valid, busy, step, done};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got code=%h valid=%b busy=%b step=%b done=%b, expected code=%h valid=%b busy=%b step=%b done=%b",
                     name, act[7:4], act[3], act[2], act[1], act[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;
        dwell = '0;
        dir   = 1'b0;
    endtask

    initial begin
        int steps, valids, dones;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle_inputs();

        // Vector table: start+stop together, then a dwell=0 single sweep.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'd0, 4'h0, 1'b1, 1'b1, 1'b0};
        for (int i = 2; i <= 16; i++)
            vecs[i] = '{1'b0, 1'b0, 1'b1, 8'd9, 4'(i - 1), 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0};

        tick();
        tick();
        check("reset_state", mk(4'h0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", mk(4'h0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 19; i++) begin
            start = vecs[i].start;
            stop  = vecs[i].stop;
            loop  = vecs[i].loop;
            dwell = vecs[i].dwell;
            tick();
            check($sformatf("vec%0d", i),
                  mk(vecs[i].exp_code, vecs[i].exp_valid, vecs[i].exp_step, vecs[i].exp_done));
        end
        idle_inputs();

        // dwell=3 single sweep; start pulse and dwell change mid-scan must be ignored.
        start = 1'b1;
        dwell = 8'd3;
        tick();
        start  = 1'b0;
        steps  = 0;
        valids = 0;
        dones  = 0;
        for (int i = 0; i < 70; i++) begin
            check($sformatf("dw3_cyc%0d", i),
                  mk((i < 64) ? 4'(i / 4) : 4'h0, i < 64, (i < 64) && (i % 4 == 0), i == 64));
            steps  += int'(step);
            valids += int'(valid);
            dones  += int'(done);
            start = (i == 20);
            if (i == 30) dwell = 8'd7;
            tick();
        end
        n_tests++;
        if (valids != 64 || steps != 16 || dones != 1) begin
            n_fail++;
            $display("FAIL dw3_counts: got valid=%0d step=%0d done=%0d, expected 64 16 1",
                     valids, steps, dones);
        end
        idle_inputs();

        // dwell=1 continuous loop for 40 cycles, then stop.
        start = 1'b1;
        dwell = 8'd1;
        loop  = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            check($sformatf("loop_cyc%0d", i),
                  mk(4'((i / 2) % 16), 1'b1, i % 2 == 0, 1'b0));
            tick();
        end
        stop = 1'b1;
        tick();
        check("stop_to_idle", mk(4'h0, 1'b0, 1'b0, 1'b0));
        stop = 1'b0;
        tick();
        check("stop_no_done", mk(4'h0, 1'b0, 1'b0, 1'b0));

        // Reset at code 9, then a fresh start resumes from code 0.
        start = 1'b1;
        loop  = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("rst_pre%0d", i), mk(4'(i), 1'b1, 1'b1, 1'b0));
            if (i == 9) rst_n = 1'b0;
            tick();
        end
        check("rst_mid_scan", mk(4'h0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_code0", mk(4'h0, 1'b1, 1'b1, 1'b0));
        tick();
        check("restart_code1", mk(4'h1, 1'b1, 1'b1, 1'b0));
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Maximum dwell: 256 cycles per code without counter overflow.
        start = 1'b1;
        dwell = 8'hFF;
        tick();
        idle_inputs();
        for (int i = 0; i < 258; i++) begin
            if (i == 0 || i == 1 || i == 255 || i == 256 || i == 257)
                check($sformatf("maxdw_cyc%0d", i),
                      mk((i < 256) ? 4'h0 : 4'h1, 1'b1, (i == 0) || (i == 256), 1'b0));
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("maxdw_stop", mk(4'h0, 1'b0, 1'b0, 1'b0));

`ifdef SCAN_SEQ_REVERSE_EN
        // Descending single sweep.
        start = 1'b1;
        dir   = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 17; i++) begin
            check($sformatf("rev_cyc%0d", i),
                  (i < 16) ? mk(4'(15 - i), 1'b1, 1'b1, 1'b0) : mk(4'h0, 1'b0, 1'b0, 1'b1));
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scan_sequencer.md
# scan_sequencer

Sequential code generator that sits directly upstream of the team's 4-to-16 line decoder and drives its four select inputs `a`, `b`, `c`, `d`. It steps through the 16 codes with a programmable dwell time per code, in single-sweep or continuous-loop mode, and runs a start/stop/done handshake with its controller. The decoder consumes `a..d` only; `valid` tells downstream logic when the decoded line is meaningful.

## Interface
- `DWELL_W`, default 8: width of the dwell input and the internal dwell counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a scan; sampled only in IDLE.
- `stop`  in  1  abort the scan; has priority over every other event.
- `loop`  in  1  1 = continuous scan, 0 = single sweep; latched at accepted start.
- `dwell`  in  DWELL_W  each code is held for dwell+1 cycles; latched at accepted start.
- `a`, `b`, `c`, `d`  out  1 each  current code; `a` is the MSB, `d` the LSB.
- `valid`  out  1  high while a code is being presented (SCAN state).
- `busy`  out  1  equals `valid`.
- `step`  out  1  one-cycle pulse in the first cycle of each new code, including code 0 after start.
- `done`  out  1  one-cycle pulse when a single sweep completes normally.

## Operation
- States: IDLE, SCAN.
- Reset (`rst_n`=0 at an edge): state IDLE. `a..d`=0, `valid`=`busy`=`step`=`done`=0, dwell counter 0, latched `loop`/`dwell` cleared.
- IDLE: code held at 0, `valid`=0. If `start`=1 and `stop`=0, the block latches `loop` and `dwell` and enters SCAN. Code = start code, counter 0, `step`=1.
- SCAN: the counter increments each cycle. When counter == latched dwell, the counter returns to 0 and the code advances by 1 modulo 16, and `step` pulses with the new code.
- Wrap (advance from 15):
  - latched `loop`=1: next code 0, stays in SCAN.
  - latched `loop`=0: goes to IDLE, code 0, `valid`=0, `done`=1 for that one cycle. No `step`.
- `stop`=1 in any state: next cycle IDLE, code 0, counter 0, no `done`, no `step`. `stop` and `start` in the same IDLE cycle leaves the block in IDLE.
- `start` during SCAN is ignored. Changes on `dwell` or `loop` during SCAN have no effect until the next accepted start.
- Dwell = 0: the code advances every cycle.
- Dwell at its maximum: each code is held 2^DWELL_W cycles with no counter overflow.
- `done` and `step` are never high in the same cycle.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Start latency: `start` sampled at edge k gives `valid`=1, code = start code, `step`=1 after edge k.
- A single sweep holds `valid` high for exactly 16·(dwell+1) cycles. `done` asserts in the first cycle after that, with `valid` already 0.
- Stop latency: 1 cycle. `stop` at edge k gives `valid`=0 and code 0 after edge k.
- Reset mid-scan behaves identically to stop, except that latched `loop`/`dwell` are also cleared.
- `done` is a level pulse of exactly one cycle. A new `start` is accepted in that same cycle, because the state is already IDLE.

## Configuration
- `SCAN_SEQ_REVERSE_EN`
- Defined: adds input `dir` (1 bit), latched at accepted start.
  - `dir`=1 (descending): start code 15, code decrements, and the wrap is the advance from 0.
  - `dir`=0: same behaviour as undefined.
- Undefined: no `dir` port. Always ascending, start code 0, wrap from 15.
- The IDLE code is 0 in both builds.

## Test plan
- Reset, then start with dwell=0, loop=0 → codes 0..15 on consecutive cycles, `step` high 16 cycles, `valid` high 16 cycles, `done` on cycle 17 with code 0.
- Start with dwell=3, loop=0 → each code held 4 cycles, `valid` high 64 cycles, exactly one `done`, `step` count 16.
- Start with dwell=1, loop=1, let it run 40 cycles → sequence 0..15 then 0..3, no `done`. Assert `stop` → next cycle IDLE, code 0, no `done`.
- `start` and `stop` together in IDLE → stays IDLE. `start` pulsed mid-scan, and `dwell` changed mid-scan → sequence and timing unchanged.
- `rst_n`=0 at code 9 of a scan → next cycle all outputs 0. A later start begins again from code 0.
- With `SCAN_SEQ_REVERSE_EN` defined, dir=1, dwell=0, loop=0 → codes 15..0 over 16 cycles, then `done` with code 0.
